// File: rtl/tie_fifo_queue_param_if.sv
// Handshake/status bundle between a TIE FIFO producer/consumer pair and the queue.
interface tie_fifo_queue_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push_req;
  logic [WIDTH-1:0] push_data;
  logic             full;
  logic             pop_req;
  logic [WIDTH-1:0] pop_data;
  logic             empty;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             almost_empty;
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  modport master (
    output push_req, push_data, pop_req, err_clr,
    input  full, pop_data, empty, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push_req, push_data, pop_req, err_clr,
    output full, pop_data, empty, count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/tie_fifo_queue_param.sv
// Show-ahead FIFO for inter-processor TIE queues: arbitrary depth, occupancy count,
// almost-full/empty thresholds and sticky overflow/underflow errors.
module tie_fifo_queue_param #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 3,
  parameter int AF_LEVEL     = 2,
  parameter int AE_LEVEL     = 1,
  parameter bit PUSH_ON_FULL = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  tie_fifo_queue_param_if.slave q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [CW-1:0]    count;
  logic             ovf, udf;
  logic             pop_ok, push_ok;

  // Flags come straight from the registered count, so they never glitch on request inputs.
  assign q.count        = count;
  assign q.empty        = (count == '0);
  assign q.full         = (count == CW'(DEPTH));
  assign q.almost_full  = (count >= CW'(AF_LEVEL));
  assign q.almost_empty = (count <= CW'(AE_LEVEL));
  assign q.overflow     = ovf;
  assign q.underflow    = udf;
  assign q.pop_data     = store[rp];

  assign pop_ok  = q.pop_req & ~q.empty;
  assign push_ok = q.push_req & (~q.full | (PUSH_ON_FULL & pop_ok));

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) store[wp] <= q.push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push_ok) wp <= (wp == LAST) ? '0 : wp + PW'(1);
      if (pop_ok)  rp <= (rp == LAST) ? '0 : rp + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A fresh error in the clearing cycle keeps the flag set.
      ovf <= (q.push_req & ~push_ok) | (ovf & ~q.err_clr);
      udf <= (q.pop_req & q.empty)   | (udf & ~q.err_clr);
    end
  end
endmodule

// File: tb/tb_tie_fifo_queue_param.sv
// Randomised + directed bench for tie_fifo_queue_param: default config and a
// 5-deep/8-bit push-on-full config driven in lockstep against a queue model.
module tb_tie_fifo_queue_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tie_fifo_queue_param_if #(.WIDTH(32), .DEPTH(3)) if0 ();
  tie_fifo_queue_param_if #(.WIDTH(8),  .DEPTH(5)) if1 ();

  tie_fifo_queue_param #(.WIDTH(32), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(1), .PUSH_ON_FULL(1'b0))
    dut0 (.clk(clk), .rst(rst), .q(if0.slave));
  tie_fifo_queue_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .PUSH_ON_FULL(1'b1))
    dut1 (.clk(clk), .rst(rst), .q(if1.slave));

  typedef logic [31:0] q_t[$];
  q_t mq[2];
  int dep[2] = '{3, 5};
  int afl[2] = '{2, 4};
  int ael[2] = '{1, 1};
  bit pof[2] = '{1'b0, 1'b1};
  logic [31:0] msk[2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  bit m_ovf[2], m_udf[2];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state(input int i);
    logic [31:0] pd, cnt;
    logic e, f, af, ae, ov, un;
    if (i == 0) begin
      pd = if0.pop_data; cnt = 32'(if0.count); e = if0.empty; f = if0.full;
      af = if0.almost_full; ae = if0.almost_empty; ov = if0.overflow; un = if0.underflow;
    end else begin
      pd = 32'(if1.pop_data); cnt = 32'(if1.count); e = if1.empty; f = if1.full;
      af = if1.almost_full; ae = if1.almost_empty; ov = if1.overflow; un = if1.underflow;
    end
    chk($sformatf("d%0d.count", i), cnt, 32'(mq[i].size()));
    chk($sformatf("d%0d.empty", i), 32'(e), 32'(mq[i].size() == 0));
    chk($sformatf("d%0d.full", i), 32'(f), 32'(mq[i].size() == dep[i]));
    chk($sformatf("d%0d.afull", i), 32'(af), 32'(mq[i].size() >= afl[i]));
    chk($sformatf("d%0d.aempty", i), 32'(ae), 32'(mq[i].size() <= ael[i]));
    chk($sformatf("d%0d.ovf", i), 32'(ov), 32'(m_ovf[i]));
    chk($sformatf("d%0d.udf", i), 32'(un), 32'(m_udf[i]));
    if (mq[i].size() > 0) chk($sformatf("d%0d.data", i), pd, mq[i][0]);
  endtask

  task automatic model_upd(input int i, input bit pu, input logic [31:0] d, input bit po, input bit clr);
    bit was_empty, was_full, pop_ok, push_ok;
    was_empty = (mq[i].size() == 0);
    was_full  = (mq[i].size() == dep[i]);
    pop_ok    = po && !was_empty;
    push_ok   = pu && (!was_full || (pof[i] && pop_ok));
    m_ovf[i]  = (pu && !push_ok) || (m_ovf[i] && !clr);
    m_udf[i]  = (po && was_empty) || (m_udf[i] && !clr);
    if (pop_ok)  void'(mq[i].pop_front());
    if (push_ok) mq[i].push_back(d & msk[i]);
  endtask

  task automatic step(input bit pu, input logic [31:0] d, input bit po, input bit clr);
    if0.push_req = pu; if0.push_data = d;      if0.pop_req = po; if0.err_clr = clr;
    if1.push_req = pu; if1.push_data = d[7:0]; if1.pop_req = po; if1.err_clr = clr;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_upd(i, pu, d, po, clr);
    @(negedge clk);
    chk_state(0);
    chk_state(1);
  endtask

  // Asserted away from the clock edge; outputs must clear before any edge arrives.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ovf[i] = 1'b0;
      m_udf[i] = 1'b0;
    end
    chk("rst.count0", 32'(if0.count), 32'd0);
    chk_state(0);
    chk_state(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    if0.push_req = 0; if0.push_data = '0; if0.pop_req = 0; if0.err_clr = 0;
    if1.push_req = 0; if1.push_data = '0; if1.pop_req = 0; if1.err_clr = 0;
    @(negedge clk);
    do_reset();

    // Async reset mid-stream with two entries
    step(1, 32'h1, 0, 0);
    step(1, 32'h2, 0, 0);
    chk("mid.count2", 32'(if0.count), 32'd2);
    #2;
    do_reset();

    // Fill/drain with overflow on the 3-deep queue
    step(1, 32'hA, 0, 0);
    step(1, 32'hB, 0, 0);
    chk("fill.af2", 32'(if0.almost_full), 32'd1);
    step(1, 32'hC, 0, 0);
    step(1, 32'hD, 0, 0);
    chk("fill.ovf", 32'(if0.overflow), 32'd1);
    chk("fill.head", if0.pop_data, 32'hA);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0);
    chk("drain.empty", 32'(if0.empty), 32'd1);
    do_reset();

    // Pointer wrap: interleaved push/pop of 0..9
    for (int v = 0; v < 10; v++) begin
      step(1, 32'(v), 0, 0);
      chk("wrap.data", if0.pop_data, 32'(v));
      step(0, 0, 1, 0);
    end

    // Simultaneous push+pop at COUNT=1 and when empty
    step(1, 32'h11, 0, 0);
    step(1, 32'h55, 1, 0);
    chk("sim.count", 32'(if0.count), 32'd1);
    chk("sim.data", if0.pop_data, 32'h55);
    step(0, 0, 1, 0);
    step(1, 32'h77, 1, 0);
    chk("sim.udf", 32'(if0.underflow), 32'd1);
    do_reset();

    // Push-on-full config: full with 1..5, then push 0x66 with pop
    for (int v = 1; v <= 5; v++) step(1, 32'(v), 0, 0);
    step(1, 32'h66, 1, 0);
    chk("pof.full", 32'(if1.full), 32'd1);
    chk("pof.ovf", 32'(if1.overflow), 32'd0);
    for (int v = 0; v < 5; v++) begin
      chk("pof.seq", 32'(if1.pop_data), (v < 4) ? 32'(v + 2) : 32'h66);
      step(0, 0, 1, 0);
    end

    // Sticky errors and clear priority
    do_reset();
    step(0, 0, 1, 0);
    chk("err.udf", 32'(if0.underflow), 32'd1);
    step(0, 0, 0, 1);
    chk("err.clr", 32'(if0.underflow), 32'd0);
    step(0, 0, 1, 1);
    chk("err.win", 32'(if0.underflow), 32'd1);
    step(0, 0, 0, 1);

    // Random traffic with occasional clears and resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2;
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
             $urandom_range(0, 15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
